// File: rtl/clk_div_prog.sv
// clk_div_prog: N_CH programmable 50%-duty clock dividers with glitch-free divisor update; define SYNC_EN to add the SYNC phase-align input.
module clk_div_prog #(
  parameter int N_CH = 4,
  parameter int CNT_W = 22,
  parameter int unsigned DEF_DIV = 2**21-1
)(
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic LOAD,
  input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] CH_SEL,
  input  logic [CNT_W-1:0] DIV_IN,
  output logic [N_CH-1:0] CLK_OUT,
  output logic [N_CH-1:0] TICK
`ifdef SYNC_EN
  , input logic SYNC
`endif
);
  localparam int SEL_W = N_CH > 1 ? $clog2(N_CH) : 1;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt, div, pend;
    logic pv, out, tck, tc, wr;
    assign tc = EN && cnt == div;
    assign wr = LOAD && CH_SEL == SEL_W'(c);
    assign CLK_OUT[c] = out;
    assign TICK[c] = tck;
    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt <= '0;
        out <= 1'b0;
        tck <= 1'b0;
        div <= CNT_W'(DEF_DIV);
        pv <= 1'b0;
      end
`ifdef SYNC_EN
      else if (SYNC) begin
        cnt <= '0;
        out <= 1'b0;
        tck <= 1'b0;
        div <= wr ? DIV_IN : pv ? pend : div;
        pv <= 1'b0;
      end
`endif
      else begin
        tck <= tc && !out;
        if (EN) begin
          cnt <= tc ? '0 : cnt + CNT_W'(1);
          out <= out ^ tc;
        end
        // divisor only changes at terminal count, so half-periods are never cut short
        if (wr && tc) begin
          div <= DIV_IN;
          pv <= 1'b0;
        end else if (wr) begin
          pend <= DIV_IN;
          pv <= 1'b1;
        end else if (tc && pv) begin
          div <= pend;
          pv <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed checks of the programmable divider (N_CH=2, CNT_W=4, DEF_DIV=3).
module tb_clk_div_prog;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, load3 = 1'b0, sync = 1'b0;
  logic ch_sel = 1'b0;
  logic [1:0] sel3 = 2'd0;
  logic [3:0] div_in = 4'd0;
  logic [1:0] clk_out, tick;
  logic [2:0] out3, tick3;
  logic e0, e1, t0, t1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  clk_div_prog #(.N_CH(2), .CNT_W(4), .DEF_DIV(3)) dut (
    .CLK(clk), .RST(rst), .EN(en), .LOAD(load), .CH_SEL(ch_sel), .DIV_IN(div_in),
    .CLK_OUT(clk_out), .TICK(tick)
`ifdef SYNC_EN
    , .SYNC(sync)
`endif
  );

  // three channels give a two-bit select, so an out-of-range address exists
  clk_div_prog #(.N_CH(3), .CNT_W(4), .DEF_DIV(3)) dut3 (
    .CLK(clk), .RST(rst), .EN(en), .LOAD(load3), .CH_SEL(sel3), .DIV_IN(div_in),
    .CLK_OUT(out3), .TICK(tick3)
`ifdef SYNC_EN
    , .SYNC(sync)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_out", {1'b0, clk_out}, 3'd0);
    chk("rst_tick", {1'b0, tick}, 3'd0);
    chk("rst_out3", out3, 3'd0);
    rst = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      load3 = (k == 2);
      sel3 = 2'd3;
      div_in = 4'd1;
      step();
      e0 = ((k / 4) % 2) == 1;
      chk("p8_out", {1'b0, clk_out}, {1'b0, e0, e0});
      chk("p8_tick", {1'b0, tick}, {1'b0, {2{k % 8 == 4}}});
      chk("oor_out3", out3, {3{e0}});
      chk("oor_tick3", tick3, {3{k % 8 == 4}});
    end
    load3 = 1'b0;
    for (int k = 17; k <= 32; k++) begin
      load = (k == 18);
      ch_sel = 1'b0;
      div_in = 4'd1;
      step();
      e0 = k >= 20 && ((k - 20) / 2) % 2 == 0;
      t0 = k >= 20 && (k - 20) % 4 == 0;
      e1 = ((k / 4) % 2) == 1;
      t1 = k % 8 == 4;
      chk("ld0_out", {1'b0, clk_out}, {1'b0, e1, e0});
      chk("ld0_tick", {1'b0, tick}, {1'b0, t1, t0});
    end
    for (int k = 33; k <= 41; k++) begin
      load = (k == 36);
      ch_sel = 1'b1;
      div_in = 4'd0;
      step();
      e0 = (k % 4) < 2;
      t0 = k % 4 == 0;
      e1 = k >= 36 && k % 2 == 0;
      t1 = e1;
      chk("tc1_out", {1'b0, clk_out}, {1'b0, e1, e0});
      chk("tc1_tick", {1'b0, tick}, {1'b0, t1, t0});
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load = (i == 2 || i == 4);
      ch_sel = 1'b1;
      div_in = (i == 2) ? 4'd5 : 4'd2;
      step();
      chk("frz_out", {1'b0, clk_out}, 3'b001);
      chk("frz_tick", {1'b0, tick}, 3'b000);
    end
    load = 1'b0;
    en = 1'b1;
    for (int k = 42; k <= 53; k++) begin
      step();
      e0 = (k % 4) < 2;
      t0 = k % 4 == 0;
      e1 = ((k - 42) / 3) % 2 == 0;
      t1 = (k - 42) % 6 == 0;
      chk("res_out", {1'b0, clk_out}, {1'b0, e1, e0});
      chk("res_tick", {1'b0, tick}, {1'b0, t1, t0});
    end
    rst = 1'b1;
    step();
    chk("mrst_out", {1'b0, clk_out}, 3'd0);
    chk("mrst_tick", {1'b0, tick}, 3'd0);
    chk("mrst_out3", out3, 3'd0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      e0 = ((k / 4) % 2) == 1;
      chk("post_out", {1'b0, clk_out}, {1'b0, e0, e0});
      chk("post_tick", {1'b0, tick}, {1'b0, {2{k == 4}}});
    end
`ifdef SYNC_EN
    load = 1'b1;
    ch_sel = 1'b0;
    div_in = 4'd1;
    step();
    load = 1'b0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_out0", {1'b0, clk_out}, 3'b000);
    step();
    chk("sync_out1", {1'b0, clk_out}, 3'b000);
    step();
    chk("sync_out2", {1'b0, clk_out}, 3'b001);
    step();
    chk("sync_out3", {1'b0, clk_out}, 3'b001);
    step();
    chk("sync_out4", {1'b0, clk_out}, 3'b010);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
